aes_dec_iter: RTL and testbench

- Iterative AES-128 inverse cipher (FIPS-197 §5.3); the decrypt counterpart of the iterative encrypt round engine.
- Executes one full inverse round per clock.
- Derives round keys backwards on the fly from the final (round-10) key, so it needs no key RAM.
- Sits beside the encrypt engine, sharing the same 128-bit data/key buses and the start/done handshake style.

---
 rtl/aes_pkg.sv | 90 +++++++++
 rtl/aes_inv_round_comb.sv | 42 ++++
 rtl/aes_dec_iter.sv | 80 ++++++++
 tb/tb_aes_dec_iter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encodings, S-box tables, Rcon and GF(2^8) helpers
// used by the iterative inverse-cipher round engine.
package aes_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b01,
        S_RUN  = 2'b10
    } state_t;

    localparam int BLK_W  = 128;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    // Row 0 of each table sits in the MSBs, so entry b lives at bits {~b,3'b000} +: 8.
    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_T = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_T[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_T[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd10:   return 8'h36;
            4'd9:    return 8'h1b;
            4'd8:    return 8'h80;
            4'd7:    return 8'h40;
            4'd6:    return 8'h20;
            4'd5:    return 8'h10;
            4'd4:    return 8'h08;
            4'd3:    return 8'h04;
            4'd2:    return 8'h02;
            4'd1:    return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] x9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] xb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] xd(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] xe(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xe(a0) ^ xb(a1) ^ xd(a2) ^ x9(a3),
                x9(a0) ^ xe(a1) ^ xb(a2) ^ xd(a3),
                xd(a0) ^ x9(a1) ^ xe(a2) ^ xb(a3),
                xb(a0) ^ xd(a1) ^ x9(a2) ^ xe(a3)};
    endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// One combinational AES inverse round plus the backward key-schedule step that
// produces the round key it consumes.
module aes_inv_round_comb
    import aes_pkg::*;
#(
    parameter int RW = 4
) (
    input  logic [BLK_W-1:0] st,
    input  logic [BLK_W-1:0] rk,
    input  logic [RW-1:0]    round,
    input  logic             last,
    output logic [BLK_W-1:0] next_st,
    output logic [BLK_W-1:0] next_rk
);
    logic [WORD_W-1:0] n0, n1, n2, n3, rot;
    logic [BLK_W-1:0]  sr, ark;

    always_comb begin
        n3  = rk[31:0]  ^ rk[63:32];
        n2  = rk[63:32] ^ rk[95:64];
        n1  = rk[95:64] ^ rk[127:96];
        rot = {n3[23:0], n3[31:24]};
        n0  = rk[127:96] ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                         ^ {rcon(4'(round)), 24'h0};
        next_rk = {n0, n1, n2, n3};
    end

    // Byte (r,c) sits at index r+4c; InvShiftRows pulls row r from column (c-r) mod 4.
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[BLK_W-1 - BYTE_W*(r + 4*c) -: BYTE_W] =
                    inv_sbox(st[BLK_W-1 - BYTE_W*(r + 4*((c - r + 4) % 4)) -: BYTE_W]);
        ark     = sr ^ next_rk;
        next_st = ark;
        if (!last)
            for (int c = 0; c < 4; c++)
                next_st[BLK_W-1 - WORD_W*c -: WORD_W] = inv_mix_col(ark[BLK_W-1 - WORD_W*c -: WORD_W]);
    end

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys derived
// backwards from the round-10 key, start/done handshake with held result.
module aes_dec_iter
    import aes_pkg::*;
#(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BLK_W-1:0] din,
    input  logic [BLK_W-1:0] key_last,
    output logic             busy,
    output logic [BLK_W-1:0] dout,
    output logic             dout_valid
);
    state_t           state, state_nx;
    logic [BLK_W-1:0] st, rk, next_st, next_rk;
    logic [RW-1:0]    round;
    logic             last;

    // Treating any count <= 1 as final keeps the engine from wrapping.
    assign last = (round <= RW'(1));

    aes_inv_round_comb #(.RW(RW)) u_round (
        .st      (st),
        .rk      (rk),
        .round   (round),
        .last    (last),
        .next_st (next_st),
        .next_rk (next_rk)
    );

    always_comb begin
        state_nx = S_IDLE;
        busy     = 1'b0;
        case (state)
            S_IDLE:  state_nx = start ? S_RUN : S_IDLE;
            S_RUN: begin
                busy     = 1'b1;
                state_nx = last ? S_IDLE : S_RUN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            st         <= '0;
            rk         <= '0;
            round      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            dout_valid <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    st    <= din ^ key_last;
                    rk    <= key_last;
                    round <= RW'(NR);
                end
                S_RUN: begin
                    rk    <= next_rk;
                    round <= round - RW'(1);
                    if (last) begin
                        dout       <= next_st;
                        dout_valid <= 1'b1;
                    end else begin
                        st <= next_st;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_iter.sv
// Bench for aes_dec_iter: algorithmic AES inverse-cipher model with a cycle-level
// handshake model, compared against the DUT every cycle, plus known-answer vectors.
module tb_aes_dec_iter;

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K9 = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] C1_K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_K   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0;
    logic [127:0] din = '0, key_last = '0;
    logic         busy, dout_valid;
    logic [127:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    aes_dec_iter dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .din        (din),
        .key_last   (key_last),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb[256], isb[256];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [7:0] rcon_of(input int r);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 1; i < r; i++) rc = gm(rc, 8'h02);
        return rc;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] k10);
        logic [7:0] s[16], t[16], k[11][16], base[4];
        logic [127:0] res;
        base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int i = 0; i < 16; i++) k[10][i] = k10[127 - 8*i -: 8];
        for (int r = 10; r >= 1; r--) begin
            for (int i = 4; i < 16; i++) k[r-1][i] = k[r][i] ^ k[r][i-4];
            for (int i = 0; i < 4; i++)
                k[r-1][i] = k[r][i] ^ sb[k[r-1][12 + (i+1) % 4]] ^ (i == 0 ? rcon_of(r) : 8'h00);
        end
        for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ k[10][i];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[w + 4*c] = isb[s[w + 4*((c - w + 4) % 4)]] ^ k[r][w + 4*c];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) begin
                    if (r == 0) s[w + 4*c] = t[w + 4*c];
                    else begin
                        s[w + 4*c] = 8'h00;
                        for (int j = 0; j < 4; j++)
                            s[w + 4*c] ^= gm(t[j + 4*c], base[(j - w + 4) % 4]);
                    end
                end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // Cycle-level handshake model: accept when idle, result appears 10 edges later.
    int           m_cnt = 0;
    logic [127:0] m_res = '0, exp_dout = '0;
    logic         exp_valid = 1'b0, exp_busy = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; exp_dout = '0; exp_valid = 1'b0; exp_busy = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin exp_valid = 1'b1; exp_dout = m_res; end
            end else if (start) begin
                m_res = aes_dec(din, key_last);
                m_cnt = 10;
            end
            exp_busy = (m_cnt > 0);
        end
    end

    always @(negedge clk) begin
        chk("busy", {127'd0, busy}, {127'd0, exp_busy});
        chk("dout_valid", {127'd0, dout_valid}, {127'd0, exp_valid});
        chk("dout", dout, exp_dout);
    end

    // ---------------- stimulus ----------------
    task automatic wait_valid(input string nm, output int cyc);
        cyc = 0;
        while (dout_valid !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (dout_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s: dout_valid not seen within %0d cycles", nm, cyc);
        end
    endtask

    int cyc, pulses;

    initial begin
        rst_n = 1'b0;
        build_tables();
        chk("model_c1", aes_dec(C1_CT, C1_K), C1_PT);
        chk("model_b", aes_dec(B_CT, B_K), B_PT);

        repeat (3) @(negedge clk);
        chk("reset_dout", dout, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // C.1 with round-key probe
        start = 1'b1; din = C1_CT; key_last = C1_K;
        @(negedge clk);
        start = 1'b0; din = '0; key_last = '0;
        @(posedge clk); #1;
        chk("rk_k9", dut.rk, C1_K9);
        wait_valid("c1_done", cyc);
        chk("c1_latency", 128'(cyc), 128'd10);
        chk("c1_dout", dout, C1_PT);
        chk("rk_k0", dut.rk, C1_K0);

        // back-to-back: start in the dout_valid cycle
        start = 1'b1; din = B_CT; key_last = B_K;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_hold", dout, C1_PT);
        wait_valid("b_done", cyc);
        chk("b2b_latency", 128'(cyc), 128'd10);
        chk("b_dout", dout, B_PT);
        @(negedge clk);

        // start held high, inputs churned while busy
        start = 1'b1; din = C1_CT; key_last = C1_K;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            din = {$urandom, $urandom, $urandom, $urandom};
            key_last = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        start = 1'b0;
        chk("held_valid", {127'd0, dout_valid}, 128'd1);
        chk("held_dout", dout, C1_PT);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            din = {$urandom, $urandom, $urandom, $urandom};
            key_last = {$urandom, $urandom, $urandom, $urandom};
        end
        start = 1'b0;
        repeat (15) @(negedge clk);

        // reset mid-operation at round counter 5
        start = 1'b1; din = C1_CT; key_last = C1_K;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk); #2;
        chk("round_at_abort", 128'(dut.round), 128'd5);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_valid", {127'd0, dout_valid}, 128'd0);
        chk("abort_dout", dout, '0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dout_valid === 1'b1) pulses++;
        end
        chk("no_pulse_after_reset", 128'(pulses), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
